regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  RISC-V integer register bank: 32 x XLEN entries, one write port, two read ports.
//  Reads are registered: 1-cycle latency, with per-port valid strobes.
//  Feeds rs1/rs2 operands to the execute stage. Takes rd writeback from the REG-based pipeline.
//  x0 reads as zero. Writes to x0 are discarded.
// PARAMETERS
//  SIZE   32  data width per entry (XLEN)
//  NREG   32  number of entries; must be a power of two
//  AW     5   address width = log2(NREG)
// PORTS
//  CLK     in   1     clock; all state changes on rising edge
//  RST_N   in   1     asynchronous reset, active low
//  WE      in   1     write enable for rd
//  WADDR   in   AW    rd address
//  WDATA   in   SIZE  rd data
//  RE1     in   1     read request, port 1 (rs1)
//  RADDR1  in   AW    rs1 address
//  RDATA1  out  SIZE  rs1 data, registered
//  RVALID1 out  1     RDATA1 holds the result of the request from the previous cycle
//  RE2     in   1     read request, port 2 (rs2)
//  RADDR2  in   AW    rs2 address
//  RDATA2  out  SIZE  rs2 data, registered
//  RVALID2 out  1     RDATA2 holds the result of the request from the previous cycle
// BEHAVIOUR
//  - Reset (RST_N=0, async): all entries cleared to 0. RDATA1/2=0. RVALID1/2=0.
//    Reset asserted mid-read drops the pending valid. No output is produced for that request.
//  - Write: on CLK rise with WE=1 and WADDR!=0, entry[WADDR] <= WDATA.
//    WE=1 with WADDR=0 has no effect.
//  - Read, each port independent:
//    - On CLK rise with REn=1, RDATAn <= value(RADDRn) and RVALIDn <= 1.
//    - On CLK rise with REn=0, RVALIDn <= 0 and RDATAn holds its previous value.
//    - RADDRn=0 always returns 0.
//  - Latency: the request is sampled at edge k. Data and valid are visible after edge k.
//    Back-to-back requests give one result per cycle.
//  - Both ports reading the same address in the same cycle return identical data.
//  - Same-cycle write and read to the same nonzero address: result depends on the macro
//    (see CONFIGURATION).
//  - Address width: only the low AW bits are used. No out-of-range condition exists.
//  - No stalls, no backpressure. The consumer must capture RDATAn while RVALIDn=1,
//    or re-request.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Collision: WE=1 and WADDR==RADDRn!=0 at the same edge.
//    - RDATAn returns the new WDATA (write-first).
//  REGFILE_BYPASS_EN undefined:
//    - Same collision returns the old stored value (read-first).
//    - The write still commits, so the next read sees WDATA.
// TESTING
//  T1 reset:
//    - Drive RST_N=0 asynchronously between edges -> RDATA1/2=0 and RVALID1/2=0
//      immediately.
//    - After release, read x1..x31 -> all 0.
//  T2 write/read:
//    - WE=1, WADDR=5, WDATA=45. Next cycle RE1=1, RADDR1=5
//      -> after that edge RDATA1=45 and RVALID1=1.
//    - Following cycle RE1=0 -> RVALID1=0 and RDATA1 stays 45.
//  T3 x0:
//    - WE=1, WADDR=0, WDATA=450.
//    - Then RE1=RE2=1, RADDR1=RADDR2=0 -> RDATA1=RDATA2=0, both valids 1.
//  T4 dual port:
//    - Preload x3=7 and x4=9.
//    - RE1=RE2=1, RADDR1=3, RADDR2=4 in one cycle -> RDATA1=7 and RDATA2=9 after one edge.
//  T5 collision:
//    - Preload x6=1. Same edge: WE=1, WADDR=6, WDATA=2, RE1=1, RADDR1=6.
//    - With REGFILE_BYPASS_EN -> RDATA1=2. Without -> RDATA1=1.
//    - Either build: a re-read of x6 -> 2.
//  T6 reset mid-op:
//    - RE1=1, RADDR1=5 with x5=45. Assert RST_N=0 before the edge
//      -> RVALID1 stays 0 and x5 is cleared to 0.

Source files
------------

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   RISC-V integer register bank: NREG entries of SIZE bits, one write port
//   (rd writeback) and two independent read ports (rs1/rs2).
//   Reads are registered: the request sampled at edge k appears on rdataN_o,
//   with rvalidN_o high, right after edge k. x0 always reads as zero and
//   writes to it are dropped.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> write-first: a read that collides with a same-edge write
//                  to the same nonzero address returns the new write data.
//     undefined -> read-first: the collision returns the old stored value.
//                  The write still commits in both builds.
//
// Parameters
//   SIZE  data width per entry (XLEN)
//   NREG  number of entries (power of two)
//   AW    address width, log2(NREG)
//
// Ports
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous reset, active low; clears entries and read outputs
//   we_i       write enable
//   waddr_i    write address (rd)
//   wdata_i    write data
//   re1_i      read request, port 1 (rs1)
//   raddr1_i   read address, port 1
//   rdata1_o   registered read data, port 1
//   rvalid1_o  rdata1_o holds the result of last cycle's request
//   re2_i      read request, port 2 (rs2)
//   raddr2_i   read address, port 2
//   rdata2_o   registered read data, port 2
//   rvalid2_o  rdata2_o holds the result of last cycle's request
// -----------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int SIZE = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [SIZE-1:0] wdata_i,
  input  logic            re1_i,
  input  logic [AW-1:0]   raddr1_i,
  output logic [SIZE-1:0] rdata1_o,
  output logic            rvalid1_o,
  input  logic            re2_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [SIZE-1:0] rdata2_o,
  output logic            rvalid2_o
);

  // Combinational view of every entry; element 0 is hardwired to zero so the
  // read muxes need no special case for x0.
  logic [SIZE-1:0] rd_view [NREG];

  // The whole bank must clear on an asynchronous reset, so entries are
  // individual flops rather than a RAM macro.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign rd_view[gi] = '0;
      end else begin : g_reg
        logic [SIZE-1:0] entry_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            entry_q <= '0;
          end else if (we_i && (waddr_i == AW'(gi))) begin
            entry_q <= wdata_i;
          end
        end

        assign rd_view[gi] = entry_q;
      end
    end
  endgenerate

  // Read-port next-state logic
  logic [SIZE-1:0] rdata1_d, rdata2_d;
  logic [SIZE-1:0] rdata1_q, rdata2_q;
  logic            rvalid1_q, rvalid2_q;
  logic [SIZE-1:0] rd1_val, rd2_val;

  always_comb begin
    rd1_val = rd_view[raddr1_i];
    rd2_val = rd_view[raddr2_i];
`ifdef REGFILE_BYPASS_EN
    // Write-first: forward the incoming rd value on an address match. x0 is
    // excluded because the write to it never happens.
    if (we_i && (waddr_i == raddr1_i) && (raddr1_i != '0)) begin
      rd1_val = wdata_i;
    end
    if (we_i && (waddr_i == raddr2_i) && (raddr2_i != '0)) begin
      rd2_val = wdata_i;
    end
`endif
  end

  // Data holds its previous value when the port is idle; only valid drops.
  always_comb begin
    rdata1_d = re1_i ? rd1_val : rdata1_q;
    rdata2_d = re2_i ? rd2_val : rdata2_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid1_q <= re1_i;
      rvalid2_q <= re2_i;
    end
  end

  assign rdata1_o  = rdata1_q;
  assign rdata2_o  = rdata2_q;
  assign rvalid1_o = rvalid1_q;
  assign rvalid2_o = rvalid2_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//   Directed-vector bench for regfile_2r1w with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, i.e. after the edge that sampled the request.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

  localparam int SIZE = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [SIZE-1:0] wdata;
  logic            re1;
  logic [AW-1:0]   raddr1;
  logic [SIZE-1:0] rdata1;
  logic            rvalid1;
  logic            re2;
  logic [AW-1:0]   raddr2;
  logic [SIZE-1:0] rdata2;
  logic            rvalid2;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_2r1w #(.SIZE(SIZE), .NREG(NREG), .AW(AW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .re1_i     (re1),
    .raddr1_i  (raddr1),
    .rdata1_o  (rdata1),
    .rvalid1_o (rvalid1),
    .re2_i     (re2),
    .raddr2_i  (raddr2),
    .rdata2_o  (rdata2),
    .rvalid2_o (rvalid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SIZE-1:0] obs,
                       input logic [SIZE-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    idle();
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  logic [SIZE-1:0] exp_coll;

  initial begin
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    repeat (2) tick();

    // Reset state
    check("rst_rdata1", rdata1, 0);
    check("rst_rvalid1", {31'd0, rvalid1}, 0);
    check("rst_rdata2", rdata2, 0);
    check("rst_rvalid2", {31'd0, rvalid2}, 0);
    #2 rst_n = 1'b1;
    tick();

    // T1: every entry reads 0 after reset, both ports, back-to-back
    for (int i = 1; i < NREG; i++) begin
      re1 = 1'b1; raddr1 = AW'(i);
      re2 = 1'b1; raddr2 = AW'(NREG - i);
      tick();
      check($sformatf("t1_rd1_x%0d", i), rdata1, 0);
      check($sformatf("t1_rd2_x%0d", NREG - i), rdata2, 0);
    end
    check("t1_rvalid1", {31'd0, rvalid1}, 1);

    // T2: write then read, then idle holds data and drops valid
    write_reg(5, 45);
    re1 = 1'b1; raddr1 = 5;
    tick();
    check("t2_rdata1", rdata1, 45);
    check("t2_rvalid1", {31'd0, rvalid1}, 1);
    check("t2_rvalid2_idle", {31'd0, rvalid2}, 0);
    idle();
    tick();
    check("t2_hold_rvalid1", {31'd0, rvalid1}, 0);
    check("t2_hold_rdata1", rdata1, 45);

    // T3: writes to x0 are discarded
    write_reg(0, 450);
    re1 = 1'b1; raddr1 = 0; re2 = 1'b1; raddr2 = 0;
    tick();
    check("t3_rdata1", rdata1, 0);
    check("t3_rdata2", rdata2, 0);
    check("t3_rvalid1", {31'd0, rvalid1}, 1);
    check("t3_rvalid2", {31'd0, rvalid2}, 1);

    // T4: independent dual-port read, then both ports on one address
    write_reg(3, 7);
    write_reg(4, 9);
    re1 = 1'b1; raddr1 = 3; re2 = 1'b1; raddr2 = 4;
    tick();
    check("t4_rdata1", rdata1, 7);
    check("t4_rdata2", rdata2, 9);
    raddr1 = 4; raddr2 = 4;
    tick();
    check("t4_same_rdata1", rdata1, 9);
    check("t4_same_rdata2", rdata2, 9);
    // Port 2 idle while port 1 reads: port 2 holds, valid drops
    re2 = 1'b0; raddr1 = 3;
    tick();
    check("t4_p1_only_rdata1", rdata1, 7);
    check("t4_p2_hold_rdata2", rdata2, 9);
    check("t4_p2_rvalid2", {31'd0, rvalid2}, 0);

    // T5: same-edge write/read collision on x6
    write_reg(6, 1);
    we = 1'b1; waddr = 6; wdata = 2;
    re1 = 1'b1; raddr1 = 6;
    re2 = 1'b1; raddr2 = 3;
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_coll = 2;
`else
    exp_coll = 1;
`endif
    check("t5_collision_rdata1", rdata1, exp_coll);
    check("t5_other_rdata2", rdata2, 7);
    idle();
    re1 = 1'b1; raddr1 = 6;
    tick();
    check("t5_reread_rdata1", rdata1, 2);

    // T6: async reset mid-operation
    re1 = 1'b1; raddr1 = 5;
    tick();
    check("t6_pre_rdata1", rdata1, 45);
    check("t6_pre_rvalid1", {31'd0, rvalid1}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_rdata1", rdata1, 0);
    check("t6_async_rvalid1", {31'd0, rvalid1}, 0);
    tick();
    check("t6_held_rvalid1", {31'd0, rvalid1}, 0);
    #2 rst_n = 1'b1;
    re1 = 1'b1; raddr1 = 5; re2 = 1'b1; raddr2 = 3;
    tick();
    check("t6_x5_cleared", rdata1, 0);
    check("t6_x3_cleared", rdata2, 0);
    check("t6_post_rvalid1", {31'd0, rvalid1}, 1);

    idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
